filter_stream_combiner: RTL and testbench
=========================================

Name: filter_stream_combiner

Overview:
- Sits directly downstream of top_level_filters; consumes the parallel threshold and brightness pixel streams.
- Aligns the two streams, selects or merges them per the frame-latched mode, and buffers the result in an output FIFO.
- Drives output_ready back to the filters as flow control and presents a valid/ready stream to the display/VGA sink.

Parameters:
- DATA_W, 8: pixel width.
- ALIGN_DEPTH, 4: per-stream alignment queue depth (power of 2).
- FIFO_DEPTH, 16: output FIFO depth (power of 2).
- AFULL_MARGIN, 4: free FIFO entries required to keep output_ready high.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- mode_in  in  2  requested combine mode: 00 thresh, 01 bright, 10 average, 11 max
- frame_start  in  1  single-cycle start-of-frame pulse
- pix_thresh  in  DATA_W  threshold-filter pixel
- valid_thresh  in  1  pix_thresh valid
- pix_bright  in  DATA_W  brightness-filter pixel
- valid_bright  in  1  pix_bright valid
- output_ready  out  1  backpressure to filters
- pix_out  out  DATA_W  combined pixel (FIFO head)
- valid_out  out  1  pix_out valid
- ready_in  in  1  sink ready
- fifo_count  out  $clog2(FIFO_DEPTH)+1  output FIFO occupancy
- overflow  out  1  sticky: a pixel was dropped

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: pix_out=0, valid_out=0, output_ready=0, fifo_count=0, overflow=0, active_mode=00; all queues empty.
- output_ready is registered: 1 when (FIFO_DEPTH - fifo_count) >= AFULL_MARGIN, else 0. First 1 is on the first clk after reset deasserts.
- Alignment queues:
  - One queue per stream. A pixel is pushed whenever its valid is high, independent of output_ready; the filters may emit up to AFULL_MARGIN pixels after output_ready drops.
  - Push into a full queue: pixel dropped, overflow set until reset.
- active_mode:
  - Latched from mode_in only on frame_start; mode_in changes mid-frame are ignored.
  - frame_start also empties both alignment queues. The output FIFO is not flushed.
  - A valid pixel in the same cycle as frame_start is pushed into the emptied queue as the first pixel of the new frame.
- Combine stage fires when the required heads are present AND the output FIFO is not full:
  - 00: thresh head required; result = thresh. Any bright head is popped and discarded in the same cycle.
  - 01: bright head required; result = bright. Any thresh head is popped and discarded in the same cycle.
  - 10: both heads required; result = (thresh + bright) >> 1. The sum is computed at DATA_W+1 bits and truncated.
  - 11: both heads required; result = max(thresh, bright).
  - Fire pops the heads used. The result is registered and written to the FIFO the next cycle.
  - Latency input to valid_out: 3 clk minimum (queue write, combine register, FIFO write), with an empty FIFO and no backpressure.
- Output FIFO:
  - First-word-fall-through: valid_out = (fifo_count != 0), pix_out = head.
  - Pop on valid_out && ready_in.
  - Simultaneous push and pop leaves the count unchanged, including at full and at empty+push.
  - Combine never writes into a full FIFO; it stalls and leaves the heads unpopped.
- Pointers wrap modulo depth; full/empty are determined with an extra pointer MSB.
- Reset mid-frame discards all queued data.

Optional Feature:
- COMBINER_STATS_EN defined:
  - Adds output frame_pix_count[19:0], reset 0.
  - An internal counter increments per output pop (valid_out && ready_in).
  - On frame_start the counter value is copied to frame_pix_count and the counter restarts. A pop in the same cycle counts toward the new frame.
- COMBINER_STATS_EN undefined: port and counter are absent; all other behaviour identical.

Decomposition:
- Package filter_stream_pkg:
  - typedef enum logic [1:0] combine_mode_e {CM_THRESH, CM_BRIGHT, CM_AVG, CM_MAX}
  - localparam PIX_W = 8
- Sub-module sync_fifo (params WIDTH, DEPTH): FWFT, synchronous clear input. Instantiated three times: two alignment queues and the output FIFO.

Test Plan:
- Reset: hold reset 5 cycles → all outputs 0; output_ready=1 on the first clk after release; fifo_count=0.
- Mode 10 (average):
  - frame_start with mode_in=10; thresh=255 and bright=100 on the same cycle → pix_out=177, valid_out 3 clk later.
  - thresh=255 two cycles before bright=100 → same single result, no extra output.
- Mode 00 with both streams valid, 10 pixels 255 - i*25 on thresh → pix_out sequence 255,230,…,30; bright pixels discarded; fifo_count stays ≤ 10.
- Backpressure:
  - ready_in=0, 20 valid pixels in mode 01 → output_ready falls when fifo_count reaches 13.
  - FIFO saturates at 16, the queue absorbs 4 pixels, overflow=0.
  - 5th excess pixel → overflow=1.
- Mode switch: mode_in changes 00→11 mid-frame → outputs stay thresh; after the next frame_start, thresh=40 and bright=90 → pix_out=90.
- COMBINER_STATS_EN: 37 pops between two frame_start pulses → frame_pix_count=37 the cycle after the second pulse.

Source files
------------

// File: rtl/filter_stream_pkg.sv
// Shared types and constants for the filter stream combiner.
package filter_stream_pkg;

   typedef enum logic [1:0] {
      CM_THRESH = 2'b00,
      CM_BRIGHT = 2'b01,
      CM_AVG    = 2'b10,
      CM_MAX    = 2'b11
   } combine_mode_e;

   localparam int PIX_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with an extra pointer MSB for full/empty.
// A clear flushes the contents; a push in the same cycle becomes the first entry.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty && !clear;
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
   assign do_push = push && (clear || !full || do_pop);
   assign drop    = push && !clear && full && !do_pop;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= (AW+1)'(do_push);
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[clear ? AW'(0) : wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/filter_stream_combiner.sv
// Aligns threshold and brightness pixel streams, combines them per frame-latched
// mode and buffers the result. Optional COMBINER_STATS_EN adds frame_pix_count.
module filter_stream_combiner
   import filter_stream_pkg::*;
#(
   parameter int DATA_W       = PIX_W,
   parameter int ALIGN_DEPTH  = 4,
   parameter int FIFO_DEPTH   = 16,
   parameter int AFULL_MARGIN = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [1:0]                    mode_in,
   input  logic                          frame_start,
   input  logic [DATA_W-1:0]             pix_thresh,
   input  logic                          valid_thresh,
   input  logic [DATA_W-1:0]             pix_bright,
   input  logic                          valid_bright,
   output logic                          output_ready,
   output logic [DATA_W-1:0]             pix_out,
   output logic                          valid_out,
   input  logic                          ready_in,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
`ifdef COMBINER_STATS_EN
   ,
   output logic [19:0]                   frame_pix_count
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int AW = $clog2(ALIGN_DEPTH) + 1;

   function automatic logic [DATA_W-1:0] avg_trunc(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
      logic [DATA_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[DATA_W:1];
   endfunction

   function automatic logic [DATA_W-1:0] max_pix(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   combine_mode_e     active_mode;
   logic [DATA_W-1:0] t_head, b_head, o_head;
   logic [AW-1:0]     t_count, b_count;
   logic              t_full, t_empty, t_drop, t_pop;
   logic              b_full, b_empty, b_drop, b_pop;
   logic [CW-1:0]     o_count;
   logic              o_full, o_empty, o_drop, o_pop;
   logic              fire, room;
   logic [DATA_W-1:0] res;
   logic [DATA_W-1:0] res_p1;
   logic              vld_p1;

   always_ff @(posedge clk) begin
      if (reset)            active_mode <= CM_THRESH;
      else if (frame_start) active_mode <= combine_mode_e'(mode_in);
   end

   sync_fifo #(.WIDTH(DATA_W), .DEPTH(ALIGN_DEPTH)) u_thresh_q (
      .clk(clk), .reset(reset), .clear(frame_start),
      .push(valid_thresh), .din(pix_thresh), .pop(t_pop),
      .dout(t_head), .count(t_count), .full(t_full), .empty(t_empty), .drop(t_drop)
   );

   sync_fifo #(.WIDTH(DATA_W), .DEPTH(ALIGN_DEPTH)) u_bright_q (
      .clk(clk), .reset(reset), .clear(frame_start),
      .push(valid_bright), .din(pix_bright), .pop(b_pop),
      .dout(b_head), .count(b_count), .full(b_full), .empty(b_empty), .drop(b_drop)
   );

   // Count the result already in flight so the FIFO is never written while full.
   assign room = (o_count + CW'(vld_p1)) < CW'(FIFO_DEPTH);

   always_comb begin
      fire  = 1'b0;
      t_pop = 1'b0;
      b_pop = 1'b0;
      res   = '0;
      case (active_mode)
         CM_THRESH: if (!t_empty && room) begin
            fire  = 1'b1;
            t_pop = 1'b1;
            b_pop = !b_empty;
            res   = t_head;
         end
         CM_BRIGHT: if (!b_empty && room) begin
            fire  = 1'b1;
            b_pop = 1'b1;
            t_pop = !t_empty;
            res   = b_head;
         end
         CM_AVG: if (!t_empty && !b_empty && room) begin
            fire  = 1'b1;
            t_pop = 1'b1;
            b_pop = 1'b1;
            res   = avg_trunc(t_head, b_head);
         end
         default: if (!t_empty && !b_empty && room) begin
            fire  = 1'b1;
            t_pop = 1'b1;
            b_pop = 1'b1;
            res   = max_pix(t_head, b_head);
         end
      endcase
   end

   // Stage p1: registered combine result
   always_ff @(posedge clk) begin
      if (reset) vld_p1 <= 1'b0;
      else       vld_p1 <= fire;
   end

   always_ff @(posedge clk) begin
      if (fire) res_p1 <= res;
   end

   assign o_pop = valid_out && ready_in;

   sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk(clk), .reset(reset), .clear(1'b0),
      .push(vld_p1), .din(res_p1), .pop(o_pop),
      .dout(o_head), .count(o_count), .full(o_full), .empty(o_empty), .drop(o_drop)
   );

   assign fifo_count = o_count;
   assign valid_out  = !o_empty;
   assign pix_out    = valid_out ? o_head : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         output_ready <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         output_ready <= (CW'(FIFO_DEPTH) - o_count) >= CW'(AFULL_MARGIN);
         if (t_drop || b_drop || o_drop) overflow <= 1'b1;
      end
   end

`ifdef COMBINER_STATS_EN
   logic [19:0] pix_cnt;

   // A pop coinciding with frame_start belongs to the new frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         pix_cnt         <= '0;
         frame_pix_count <= '0;
      end else if (frame_start) begin
         frame_pix_count <= pix_cnt;
         pix_cnt         <= 20'(o_pop);
      end else begin
         pix_cnt         <= pix_cnt + 20'(o_pop);
      end
   end
`endif

endmodule

// File: tb/tb_filter_stream_combiner.sv
// Directed self-checking bench for filter_stream_combiner (stats checks need COMBINER_STATS_EN).
module tb_filter_stream_combiner;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] mode_in;
   logic       frame_start;
   logic [7:0] pix_thresh, pix_bright;
   logic       valid_thresh, valid_bright;
   logic       output_ready;
   logic [7:0] pix_out;
   logic       valid_out;
   logic       ready_in;
   logic [4:0] fifo_count;
   logic       overflow;
`ifdef COMBINER_STATS_EN
   logic [19:0] frame_pix_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] got[$];
   int max_cnt;

   filter_stream_combiner dut (
      .clk(clk), .reset(reset), .mode_in(mode_in), .frame_start(frame_start),
      .pix_thresh(pix_thresh), .valid_thresh(valid_thresh),
      .pix_bright(pix_bright), .valid_bright(valid_bright),
      .output_ready(output_ready), .pix_out(pix_out), .valid_out(valid_out),
      .ready_in(ready_in), .fifo_count(fifo_count), .overflow(overflow)
`ifdef COMBINER_STATS_EN
      , .frame_pix_count(frame_pix_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset && valid_out && ready_in) got.push_back(pix_out);
      if (!reset && int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      frame_start  = 1'b0;
      valid_thresh = 1'b0;
      valid_bright = 1'b0;
   endtask

   function automatic logic [31:0] got_at(input int i);
      return (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF;
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int drop_at;
      int prev_cnt;
      logic seen_rdy;
      reset = 1'b1; mode_in = 2'b00; ready_in = 1'b1;
      pix_thresh = '0; pix_bright = '0;
      idle_inputs();
      max_cnt = 0;

      // Reset behaviour
      repeat (5) tick();
      check_eq("rst_pix_out", pix_out, 0);
      check_eq("rst_valid_out", valid_out, 0);
      check_eq("rst_output_ready", output_ready, 0);
      check_eq("rst_fifo_count", fifo_count, 0);
      check_eq("rst_overflow", overflow, 0);
      reset = 1'b0;
      tick();
      check_eq("ready_after_reset", output_ready, 1);
      check_eq("count_after_reset", fifo_count, 0);

      // Average mode, aligned inputs: (255+100)>>1 = 177 after 3 clocks
      got.delete();
      frame_start = 1'b1; mode_in = 2'b10;
      pix_thresh = 8'd255; valid_thresh = 1'b1;
      pix_bright = 8'd100; valid_bright = 1'b1;
      tick();
      idle_inputs();
      tick();
      check_eq("avg_latency_early", valid_out, 0);
      tick();
      check_eq("avg_valid_3clk", valid_out, 1);
      check_eq("avg_pix", pix_out, 177);
      repeat (4) tick();
      check_eq("avg_count1", got.size(), 1);

      // Average mode, misaligned arrival
      got.delete();
      pix_thresh = 8'd255; valid_thresh = 1'b1;
      tick();
      idle_inputs();
      tick();
      pix_bright = 8'd100; valid_bright = 1'b1;
      tick();
      idle_inputs();
      repeat (8) tick();
      check_eq("avg_skew_count", got.size(), 1);
      check_eq("avg_skew_pix", got_at(0), 177);

      // Threshold mode with bright discarded
      got.delete();
      max_cnt = 0;
      mode_in = 2'b00;
      for (int i = 0; i < 10; i++) begin
         frame_start  = (i == 0);
         pix_thresh   = 8'(255 - i * 25); valid_thresh = 1'b1;
         pix_bright   = 8'(i + 7);        valid_bright = 1'b1;
         tick();
      end
      idle_inputs();
      repeat (8) tick();
      check_eq("thr_count", got.size(), 10);
      for (int i = 0; i < 10; i++) check_eq($sformatf("thr_pix%0d", i), got_at(i), 32'(255 - i * 25));
      check_eq("thr_max_count_le10", (max_cnt <= 10), 1);

      // Mode change mid-frame ignored until next frame_start
      got.delete();
      mode_in = 2'b11;
      pix_thresh = 8'd40; valid_thresh = 1'b1;
      pix_bright = 8'd90; valid_bright = 1'b1;
      tick();
      idle_inputs();
      repeat (6) tick();
      check_eq("midframe_count", got.size(), 1);
      check_eq("midframe_pix", got_at(0), 40);
      got.delete();
      frame_start = 1'b1;
      pix_thresh = 8'd40; valid_thresh = 1'b1;
      pix_bright = 8'd90; valid_bright = 1'b1;
      tick();
      idle_inputs();
      repeat (6) tick();
      check_eq("max_count", got.size(), 1);
      check_eq("max_pix", got_at(0), 90);

      // Backpressure in bright mode
      got.delete();
      ready_in = 1'b0; mode_in = 2'b01;
      drop_at = -1; prev_cnt = int'(fifo_count); seen_rdy = output_ready;
      for (int i = 0; i < 30; i++) begin
         frame_start  = (i == 0);
         valid_bright = (i < 20);
         pix_bright   = 8'(i + 1);
         tick();
         if (seen_rdy && !output_ready && drop_at < 0) drop_at = prev_cnt;
         seen_rdy = output_ready;
         prev_cnt = int'(fifo_count);
      end
      idle_inputs();
      check_eq("bp_ready_drop_at", drop_at, 13);
      check_eq("bp_fifo_full", fifo_count, 16);
      check_eq("bp_output_ready", output_ready, 0);
      check_eq("bp_no_overflow", overflow, 0);
      check_eq("bp_head", pix_out, 1);
      pix_bright = 8'd21; valid_bright = 1'b1;
      tick();
      idle_inputs();
      check_eq("bp_overflow", overflow, 1);
      ready_in = 1'b1;
      repeat (30) tick();
      check_eq("bp_drain_count", got.size(), 20);
      for (int i = 0; i < 20; i++) check_eq($sformatf("bp_pix%0d", i), got_at(i), 32'(i + 1));
      check_eq("bp_overflow_sticky", overflow, 1);

      // Reset mid-frame discards queued data
      ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         frame_start = (i == 0);
         pix_bright = 8'(50 + i); valid_bright = 1'b1;
         tick();
      end
      idle_inputs();
      tick();
      reset = 1'b1;
      tick();
      check_eq("mid_rst_count", fifo_count, 0);
      check_eq("mid_rst_overflow", overflow, 0);
      reset = 1'b0;
      repeat (6) tick();
      check_eq("mid_rst_empty", fifo_count, 0);
      check_eq("mid_rst_valid", valid_out, 0);
      ready_in = 1'b1;

`ifdef COMBINER_STATS_EN
      // Pops per frame
      got.delete();
      mode_in = 2'b00;
      for (int i = 0; i < 37; i++) begin
         frame_start = (i == 0);
         pix_thresh = 8'(i); valid_thresh = 1'b1;
         tick();
      end
      idle_inputs();
      repeat (6) tick();
      check_eq("stats_pops", got.size(), 37);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check_eq("stats_frame_pix_count", frame_pix_count, 37);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
